// File: rtl/drive_cmd_gen.sv
// drive_cmd_gen: command source for the motor UART transmitter.
// Turns four direction key levels and two speed pulses into a debounced
// 4-bit motion code and a saturating 4-bit speed level. The command is
// offered over a valid/ready handshake, and the current command is re-offered
// periodically as a heartbeat.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   key_w/a/s/d  direction key levels (already synchronised)
//   spd_up/dn    single-cycle speed step pulses
//   ready        downstream can accept a command
//   move_cmd     committed motion code (8 = stop)
//   speed_level  committed speed level (1..SPEED_MAX)
//   valid        command offered; outputs are frozen while high
module drive_cmd_gen #(
    parameter int unsigned STABLE_CYCLES  = 500_000,
    parameter int unsigned REFRESH_CYCLES = 5_000_000,
    parameter int unsigned SPEED_INIT     = 5,
    parameter int unsigned SPEED_MAX      = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_w,
    input  logic       key_a,
    input  logic       key_s,
    input  logic       key_d,
    input  logic       spd_up,
    input  logic       spd_dn,
    input  logic       ready,
    output logic [3:0] move_cmd,
    output logic [3:0] speed_level,
    output logic       valid
);

    localparam int CNT_W = (STABLE_CYCLES > 0) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [3:0]       SPD_MAX  = 4'(SPEED_MAX);
    localparam logic [3:0]       SPD_INIT = 4'(SPEED_INIT);
    localparam logic [3:0]       CMD_STOP = 4'd8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    logic [3:0]       dec;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       spd_q, spd_d;
    logic [0:0]       state_q, state_d;
    logic [REF_W-1:0] ref_q, ref_d;
    logic [3:0]       move_q, move_d;
    logic [3:0]       lvl_q, lvl_d;
    logic             valid_q, valid_d;
    logic             stable;

    // Key decode: anything outside the eight legal combinations means stop.
    always_comb begin
        case ({key_w, key_a, key_s, key_d})
            4'b1000: dec = 4'd0;
            4'b1100: dec = 4'd1;
            4'b1001: dec = 4'd2;
            4'b0010: dec = 4'd3;
            4'b0100: dec = 4'd4;
            4'b0001: dec = 4'd5;
            4'b0110: dec = 4'd6;
            4'b0011: dec = 4'd7;
            default: dec = CMD_STOP;
        endcase
    end

    assign stable = (cnt_q == CNT_MAX);

    // Stability filter: any change of the decoded pattern restarts the count;
    // the count saturates once the candidate is stable.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (dec != cand_q) begin
            cand_d = dec;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Speed runs in every state so changes made during a stall are queued.
    always_comb begin
        spd_d = spd_q;
        if (spd_up && !spd_dn)
            spd_d = (spd_q >= SPD_MAX) ? SPD_MAX : spd_q + 4'd1;
        else if (spd_dn && !spd_up)
            spd_d = (spd_q <= 4'd1) ? 4'd1 : spd_q - 4'd1;
    end

    // Offer FSM: a real change takes priority over the heartbeat; the
    // refresh counter only runs while idle.
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        move_d  = move_q;
        lvl_d   = lvl_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (stable && ((cand_q != move_q) || (spd_q != lvl_q))) begin
                    move_d  = cand_q;
                    lvl_d   = spd_q;
                    valid_d = 1'b1;
                    ref_d   = '0;
                    state_d = PEND;
                end else if (ref_q == REF_LAST) begin
                    valid_d = 1'b1;
                    ref_d   = '0;
                    state_d = PEND;
                end else begin
                    ref_d = ref_q + 1'b1;
                end
            end
            PEND: begin
                if (ready) begin
                    valid_d = 1'b0;
                    ref_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ref_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q  <= CMD_STOP;
            cnt_q   <= '0;
            spd_q   <= SPD_INIT;
            state_q <= IDLE;
            ref_q   <= '0;
            move_q  <= CMD_STOP;
            lvl_q   <= SPD_INIT;
            valid_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            spd_q   <= spd_d;
            state_q <= state_d;
            ref_q   <= ref_d;
            move_q  <= move_d;
            lvl_q   <= lvl_d;
            valid_q <= valid_d;
        end
    end

    assign move_cmd    = move_q;
    assign speed_level = lvl_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_drive_cmd_gen.sv
module tb_drive_cmd_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_w = 1'b0, key_a = 1'b0, key_s = 1'b0, key_d = 1'b0;
    logic       spd_up = 1'b0, spd_dn = 1'b0;
    logic       ready = 1'b1;
    logic [3:0] move_cmd, speed_level;
    logic       valid;

    int cyc = 0;
    int vectors = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] m;
        logic [3:0] s;
        int         cyc;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    drive_cmd_gen #(
        .STABLE_CYCLES (4),
        .REFRESH_CYCLES(100),
        .SPEED_INIT    (5),
        .SPEED_MAX     (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_w      (key_w),
        .key_a      (key_a),
        .key_s      (key_s),
        .key_d      (key_d),
        .spd_up     (spd_up),
        .spd_dn     (spd_dn),
        .ready      (ready),
        .move_cmd   (move_cmd),
        .speed_level(speed_level),
        .valid      (valid)
    );

    task automatic check(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0d, required %0d", nm, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] m, input logic [3:0] s, input int c);
        exp_t e;
        e.m = m;
        e.s = s;
        e.cyc = c;
        q.push_back(e);
    endtask

    task automatic set_keys(input logic [3:0] wasd);
        {key_w, key_a, key_s, key_d} = wasd;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(nm, q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every new offer and checks that an
    // offer is held, unchanged, until it is accepted.
    logic       pv = 1'b0, pr = 1'b0;
    logic [3:0] pm = 4'd0, ps = 4'd0;
    exp_t       me;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && !pv) begin
                if (q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_offer at cyc %0d: got %0d/%0d, required no offer",
                             cyc, move_cmd, speed_level);
                end else begin
                    me = q.pop_front();
                    check("offer_move", move_cmd, me.m);
                    check("offer_speed", speed_level, me.s);
                    if (me.cyc >= 0) check("offer_cycle", cyc, me.cyc);
                end
            end else if (valid && pv) begin
                check("valid_kept_after_ready", pr, 0);
                check("held_move", move_cmd, pm);
                check("held_speed", speed_level, ps);
            end
        end
        pv = valid;
        pr = ready;
        pm = move_cmd;
        ps = speed_level;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, d, p, c0;
        // Reset state
        repeat (3) tick();
        check("reset_valid", valid, 0);
        check("reset_move", move_cmd, 8);
        check("reset_speed", speed_level, 5);
        rst = 1'b0;
        c0 = cyc;

        // 1: idle heartbeat every 101 cycles, first one 100 cycles after reset
        push(4'd8, 4'd5, c0 + 100);
        push(4'd8, 4'd5, c0 + 201);
        for (int i = 0; i < 250; i++) begin
            tick();
            check("idle_move", move_cmd, 8);
            check("idle_speed", speed_level, 5);
        end
        wait_drain("heartbeat_drain", 5);

        // 2: w+a commits 5 cycles after sampling; a 3-cycle glitch is ignored
        c = cyc;
        set_keys(4'b1100);
        push(4'd1, 4'd5, c + 6);
        wait_drain("wa_drain", 20);
        set_keys(4'b1000);
        repeat (3) tick();
        set_keys(4'b1100);
        repeat (12) tick();
        check("glitch_move", move_cmd, 1);
        check("glitch_valid", valid, 0);

        // 3: stalled offer stays frozen while speed saturates underneath
        c = cyc;
        ready = 1'b0;
        set_keys(4'b0010);
        push(4'd3, 4'd5, c + 6);
        repeat (6) tick();
        for (int i = 0; i < 6; i++) begin
            spd_up = 1'b1;
            tick();
            spd_up = 1'b0;
            tick();
        end
        check("stall_valid", valid, 1);
        check("stall_move", move_cmd, 3);
        check("stall_speed", speed_level, 5);
        d = cyc;
        push(4'd3, 4'd9, d + 2);
        ready = 1'b1;
        wait_drain("stall_drain", 10);

        // 4: speed steps down and floors at 1; simultaneous pulses cancel
        for (int i = 1; i <= 10; i++) begin
            p = cyc;
            spd_dn = 1'b1;
            if (i <= 8) push(4'd3, 4'(9 - i), p + 2);
            tick();
            spd_dn = 1'b0;
            repeat (3) tick();
        end
        wait_drain("spd_dn_drain", 5);
        spd_up = 1'b1;
        spd_dn = 1'b1;
        tick();
        spd_up = 1'b0;
        spd_dn = 1'b0;
        repeat (8) tick();
        check("floor_speed", speed_level, 1);
        check("both_valid", valid, 0);

        // 5: illegal combinations decode to stop
        c = cyc;
        set_keys(4'b1010);
        push(4'd8, 4'd1, c + 6);
        wait_drain("ws_drain", 20);
        c = cyc;
        set_keys(4'b0001);
        push(4'd5, 4'd1, c + 6);
        wait_drain("d_drain", 20);
        c = cyc;
        set_keys(4'b0111);
        push(4'd8, 4'd1, c + 6);
        wait_drain("ads_drain", 20);
        check("ads_move", move_cmd, 8);

        // 6: reset during a stalled offer abandons it
        c = cyc;
        ready = 1'b0;
        set_keys(4'b1000);
        push(4'd0, 4'd1, c + 6);
        repeat (7) tick();
        check("pend_valid", valid, 1);
        rst = 1'b1;
        ready = 1'b1;
        set_keys(4'b0000);
        tick();
        check("rst_valid", valid, 0);
        check("rst_move", move_cmd, 8);
        check("rst_speed", speed_level, 5);
        rst = 1'b0;
        repeat (20) tick();
        check("post_rst_valid", valid, 0);
        check("queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
